rr_arbiter_5: RTL and testbench

Round-robin arbiter sharing one downstream resource among `N` requesters (default 5, matching the 5-bit OR-reduction datapath). The block collapses the request vector with a bitwise OR to detect pending work. It issues a registered one-hot grant starting from a rotating priority pointer and holds that grant until the owner releases it. It sits between the requesting units and the shared datapath and is the only block that drives the datapath's select.

---
 rtl/rr_arbiter_5.sv | 165 ++++++++++++++++
 tb/tb_rr_arbiter_5.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_5.sv
// rtl/rr_arbiter_5.sv - round-robin arbiter with registered one-hot grant held until release
//
// Purpose: shares one downstream resource among N requesters. A rotating
// pointer sets the search start; the winner holds the grant until it pulses
// done or withdraws its request, after which the pointer moves one past it.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> a grant held HOLD_LIMIT GRANT cycles is forcibly released and
//                timeout pulses for the following cycle
//   undefined -> no hold counter; timeout is constant 0
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   req       in   N  level request per requester
//   done      in   1  release pulse from the current owner (ignored when idle)
//   grant     out  N  registered one-hot grant, zero when idle
//   grant_id  out  3  binary index of the owner, zero when idle
//   busy      out  1  high while a grant is held
//   any_req   out  1  combinational OR of req
//   timeout   out  1  one-cycle pulse after a forced release

module rr_arbiter_5 #(
    parameter int N          = 5,
    parameter int HOLD_LIMIT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic [2:0]   grant_id,
    output logic         busy,
    output logic         any_req,
    output logic         timeout
);

    if (N < 2 || N > 8 || HOLD_LIMIT < 1) begin : g_bad_cfg
        $error("rr_arbiter_5: N must be 2..8 and HOLD_LIMIT at least 1");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic [2:0]   grant_id_q, grant_id_d;
    logic [2:0]   ptr_q, ptr_d;

    logic         sel_found;
    logic [2:0]   sel_id;
    int           idx;

    logic         norm_rel;
    logic         force_rel;
    logic         release_now;

    assign any_req  = |req;
    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = |grant_q;

    // Search from ptr upward with wrap. Iterating offsets from the far end
    // down lets the smallest offset win without a break.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = 3'd0;
        idx       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(ptr_q) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx[2:0]]) begin
                sel_found = 1'b1;
                sel_id    = idx[2:0];
            end
        end
    end

    // Owner releases via done or by dropping its own request; both in the
    // same cycle still count as a single release.
    assign norm_rel    = (state_q == ST_GRANT) && (done || !req[grant_id_q]);
    assign release_now = norm_rel || ((state_q == ST_GRANT) && force_rel);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << sel_id;
                    grant_id_d = sel_id;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    grant_d    = '0;
                    grant_id_d = 3'd0;
                    ptr_d      = (grant_id_q == 3'(N - 1)) ? 3'd0 : grant_id_q + 3'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= 3'd0;
            ptr_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_LIMIT + 1);

    logic [CW-1:0] hold_cnt_q;
    logic          timeout_q;

    // hold_cnt counts completed GRANT cycles before the current edge, so the
    // HOLD_LIMIT-th GRANT cycle is the one where it equals HOLD_LIMIT-1.
    assign force_rel = (hold_cnt_q == CW'(HOLD_LIMIT - 1));
    assign timeout   = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                hold_cnt_q <= '0;
            end else if (norm_rel) begin
                hold_cnt_q <= '0;
            end else if (force_rel) begin
                hold_cnt_q <= '0;
                timeout_q  <= 1'b1;
            end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_5.sv
// tb/tb_rr_arbiter_5.sv - self-checking bench for rr_arbiter_5 against a behavioural model
module tb_rr_arbiter_5;

    localparam int N  = 5;
    localparam int HL = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic [2:0]   grant_id;
    logic         busy;
    logic         any_req;
    logic         timeout;

    int checks;
    int errors;

    // Behavioural model: owner index (-1 = idle), pointer, cycles held.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    rr_arbiter_5 #(.N(N), .HOLD_LIMIT(HL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .any_req  (any_req),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [2:0] exp_id();
        return (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    // Wait for the rising edge, advance the model from the sampled inputs,
    // then step 1 time unit past the edge so outputs are settled.
    task automatic model_edge();
        @(posedge clk);
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (req != '0) begin
                for (int off = N - 1; off >= 0; off--) begin
                    if (req[(m_ptr + off) % N]) m_owner = (m_ptr + off) % N;
                end
                m_held = 0;
            end
        end else begin
            m_held++;
            if (done || !req[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (TO_EN && m_held == HL) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_to    = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive_step(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        model_edge();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 5'b11111;
        done  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 5'b00000 || busy !== 1'b0 || grant_id !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%b busy=%b id=%0d to=%b expected 00000/0/0/0",
                     grant, busy, grant_id, timeout);
        end
        checks++;
        if (any_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_any_req: got %b expected 1", any_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        model_reset();
    endtask

    task automatic test_single();
        apply_reset();
        drive_step(5'b00100, 1'b0);
        checks++;
        if (grant !== 5'b00100 || grant_id !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b id=%0d busy=%b expected 00100/2/1", grant, grant_id, busy);
        end
        drive_step(5'b00100, 1'b1);
        checks++;
        if (grant !== 5'b00000 || busy !== 1'b0) begin
            errork_line("single_release", grant, 5'b00000);
        end
        drive_step(5'b00100, 1'b0);
        checks++;
        if (grant !== 5'b00100 || grant_id !== 3'd2) begin
            errors++;
            $display("FAIL single_regrant: grant=%b id=%0d expected 00100/2", grant, grant_id);
        end
    endtask

    task automatic errork_line(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        errors++;
        $display("FAIL %s: grant=%b expected %b", name, got, exp);
    endtask

    task automatic test_rotation();
        int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive_step(5'b11111, 1'b0);
            checks++;
            if (busy !== 1'b1 || grant_id !== 3'(exp_seq[k]) || grant !== exp_grant()) begin
                errors++;
                $display("FAIL rotation[%0d]: id=%0d grant=%b expected id %0d", k, grant_id, grant, exp_seq[k]);
            end
            drive_step(5'b11111, 1'b1);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rotation_idle[%0d]: busy=%b expected 0", k, busy);
            end
        end
    endtask

    task automatic test_wrap_skip();
        apply_reset();
        drive_step(5'b01000, 1'b0);
        drive_step(5'b01000, 1'b1);
        drive_step(5'b01010, 1'b0);
        checks++;
        if (grant_id !== 3'd1 || grant !== 5'b00010) begin
            errors++;
            $display("FAIL wrap_skip: id=%0d grant=%b expected 1/00010", grant_id, grant);
        end
        drive_step(5'b01010, 1'b1);
        drive_step(5'b01010, 1'b0);
        checks++;
        if (grant_id !== 3'd3 || grant !== 5'b01000) begin
            errors++;
            $display("FAIL wrap_next: id=%0d grant=%b expected 3/01000", grant_id, grant);
        end
    endtask

    task automatic test_withdraw();
        apply_reset();
        drive_step(5'b00010, 1'b0);
        @(negedge clk);
        req  = 5'b00100;
        done = 1'b0;
        #1;
        checks++;
        if (any_req !== 1'b1 || grant !== 5'b00010) begin
            errors++;
            $display("FAIL withdraw_comb: any_req=%b grant=%b expected 1/00010", any_req, grant);
        end
        model_edge();
        checks++;
        if (grant !== 5'b00000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_release: grant=%b busy=%b expected 00000/0", grant, busy);
        end
        @(negedge clk);
        req = 5'b00000;
        #1;
        checks++;
        if (any_req !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_any_req: got %b expected 0", any_req);
        end
        req = 5'b00110;
        model_edge();
        checks++;
        if (grant_id !== 3'd2) begin
            errors++;
            $display("FAIL withdraw_ptr: id=%0d expected 2", grant_id);
        end
    endtask

    task automatic test_hold();
        int pulses = 0;
        int bad    = 0;
        apply_reset();
        for (int k = 0; k < 110; k++) begin
            drive_step(5'b00011, 1'b0);
            if (timeout === 1'b1) pulses++;
            if (grant !== exp_grant() || timeout !== m_to) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_model: %0d cycles differed from model, expected 0", bad);
        end
        checks++;
        if (!TO_EN && (grant !== 5'b00001 || pulses != 0)) begin
            errors++;
            $display("FAIL hold_forever: grant=%b pulses=%0d expected 00001/0", grant, pulses);
        end else if (TO_EN && pulses == 0) begin
            errors++;
            $display("FAIL hold_timeout: pulses=%0d expected nonzero", pulses);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         d;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            r    = N'($urandom);
            d    = ($urandom_range(0, 2) == 0);
            req  = r;
            done = d;
            #1;
            checks++;
            if (any_req !== (|r)) begin
                errors++;
                $display("FAIL rand_any_req[%0d]: got %b expected %b", k, any_req, |r);
            end
            model_edge();
            checks++;
            if (grant !== exp_grant() || grant_id !== exp_id() || busy !== (m_owner >= 0)
                || timeout !== m_to) begin
                errors++;
                $display("FAIL rand_step[%0d]: grant=%b id=%0d busy=%b to=%b expected %b/%0d/%b/%b",
                         k, grant, grant_id, busy, timeout, exp_grant(), exp_id(), m_owner >= 0, m_to);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_step(5'b11111, 1'b1);
        drive_step(5'b11111, 1'b1);
        drive_step(5'b11111, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 5'b00000 || busy !== 1'b0 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: grant=%b busy=%b id=%0d expected 00000/0/0", grant, busy, grant_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive_step(5'b11111, 1'b0);
        checks++;
        if (grant_id !== 3'd0 || grant !== 5'b00001) begin
            errors++;
            $display("FAIL async_ptr_restart: id=%0d grant=%b expected 0/00001", grant_id, grant);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        done   = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_wrap_skip();
        test_withdraw();
        test_hold();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
